// File: rtl/xover_coeff_ctrl.sv
// Coefficient shadow/active bank controller and sample-valid re-timer for the stereo crossover.
// Optional shadow readback port is enabled by defining XOVER_COEFF_READBACK_EN.
module xover_coeff_ctrl #(
  parameter int NBITS = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_mck,
  input  logic             i_rstn,
  input  logic             i_wr_en,
  input  logic [3:0]       i_wr_addr,
  input  logic [NBITS-1:0] i_wr_data,
  input  logic             i_commit,
  input  logic             i_sample_valid,
  input  logic             i_busy_l,
  input  logic             i_busy_r,
`ifdef XOVER_COEFF_READBACK_EN
  input  logic [3:0]       i_rd_addr,
  output logic [NBITS-1:0] o_rd_data,
`endif
  output logic             o_sample_valid,
  output logic [NBITS-1:0] o_lp_a0,
  output logic [NBITS-1:0] o_lp_a1,
  output logic [NBITS-1:0] o_lp_a2,
  output logic [NBITS-1:0] o_lp_b1,
  output logic [NBITS-1:0] o_lp_b2,
  output logic [NBITS-1:0] o_hp_a0,
  output logic [NBITS-1:0] o_hp_a1,
  output logic [NBITS-1:0] o_hp_a2,
  output logic [NBITS-1:0] o_hp_b1,
  output logic [NBITS-1:0] o_hp_b2,
  output logic             o_commit_pending,
  output logic             o_commit_done,
  output logic             o_wr_reject,
  output logic             o_coeff_valid,
  output logic [CNT_W-1:0] o_swap_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } state_t;

  localparam int NCOEF = 10;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shadow_q [NCOEF];
  logic [NBITS-1:0] shadow_d [NCOEF];
  logic [NBITS-1:0] active_q [NCOEF];
  logic [NBITS-1:0] active_d [NCOEF];
  logic             sv_q, sv_d;
  logic             v_d2_q, v_d2_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             reject_q, reject_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             quiet;
  logic             wr_ok;

  // Commit handshake: i_commit is a one-cycle request taken only in IDLE; o_commit_pending
  // holds from acceptance until the swap cycle, in which o_commit_done pulses for one cycle.
  always_comb begin
    sv_d      = i_sample_valid;
    v_d2_d    = sv_q;
    quiet     = !i_sample_valid && !sv_q && !v_d2_q && !i_busy_l && !i_busy_r;
    wr_ok     = i_wr_en && (state_q == ST_IDLE) && (i_wr_addr <= 4'd9);
    reject_d  = i_wr_en && !wr_ok;
    shadow_d  = shadow_q;
    active_d  = active_q;
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    count_d   = count_q;
    for (int i = 0; i < NCOEF; i++) begin
      if (wr_ok && (i_wr_addr == 4'(i))) shadow_d[i] = i_wr_data;
    end
    case (state_q)
      ST_IDLE: begin
        if (i_commit) begin
          state_d   = ST_PENDING;
          pending_d = 1'b1;
        end
      end
      // The swap edge: outputs of the SWAP cycle already carry the new set.
      ST_PENDING: begin
        if (quiet) begin
          state_d   = ST_SWAP;
          active_d  = shadow_q;
          done_d    = 1'b1;
          valid_d   = 1'b1;
          count_d   = count_q + CNT_W'(1);
          pending_d = 1'b0;
        end
      end
      ST_SWAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_mck or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      sv_q      <= 1'b0;
      v_d2_q    <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      reject_q  <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      for (int i = 0; i < NCOEF; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sv_q      <= sv_d;
      v_d2_q    <= v_d2_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      reject_q  <= reject_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

`ifdef XOVER_COEFF_READBACK_EN
  logic [NBITS-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NCOEF; i++) begin
      if (i_rd_addr == 4'(i)) rd_data_d = shadow_q[i];
    end
  end

  always_ff @(posedge i_mck or negedge i_rstn) begin
    if (!i_rstn) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign o_rd_data = rd_data_q;
`endif

  assign o_sample_valid   = sv_q;
  assign o_lp_a0          = active_q[0];
  assign o_lp_a1          = active_q[1];
  assign o_lp_a2          = active_q[2];
  assign o_lp_b1          = active_q[3];
  assign o_lp_b2          = active_q[4];
  assign o_hp_a0          = active_q[5];
  assign o_hp_a1          = active_q[6];
  assign o_hp_a2          = active_q[7];
  assign o_hp_b1          = active_q[8];
  assign o_hp_b2          = active_q[9];
  assign o_commit_pending = pending_q;
  assign o_commit_done    = done_q;
  assign o_wr_reject      = reject_q;
  assign o_coeff_valid    = valid_q;
  assign o_swap_count     = count_q;

endmodule

// File: tb/tb_xover_coeff_ctrl.sv
// Bench for xover_coeff_ctrl: directed vectors, swap/reject scoreboard drained by a negedge monitor.
// Readback checks are compiled in when XOVER_COEFF_READBACK_EN is defined.
module tb_xover_coeff_ctrl;
  localparam int NBITS = 32;
  localparam int CNT_W = 8;
  localparam int NC    = 10;
  localparam int W     = NC*NBITS + CNT_W + 2;

  logic             i_mck = 1'b0;
  logic             i_rstn;
  logic             i_wr_en;
  logic [3:0]       i_wr_addr;
  logic [NBITS-1:0] i_wr_data;
  logic             i_commit;
  logic             i_sample_valid;
  logic             i_busy_l;
  logic             i_busy_r;
  logic             o_sample_valid;
  logic [NBITS-1:0] o_lp_a0, o_lp_a1, o_lp_a2, o_lp_b1, o_lp_b2;
  logic [NBITS-1:0] o_hp_a0, o_hp_a1, o_hp_a2, o_hp_b1, o_hp_b2;
  logic             o_commit_pending;
  logic             o_commit_done;
  logic             o_wr_reject;
  logic             o_coeff_valid;
  logic [CNT_W-1:0] o_swap_count;
`ifdef XOVER_COEFF_READBACK_EN
  logic [3:0]       i_rd_addr;
  logic [NBITS-1:0] o_rd_data;
`endif

  xover_coeff_ctrl #(.NBITS(NBITS), .CNT_W(CNT_W)) dut (
    .i_mck(i_mck), .i_rstn(i_rstn), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_commit(i_commit), .i_sample_valid(i_sample_valid),
    .i_busy_l(i_busy_l), .i_busy_r(i_busy_r),
`ifdef XOVER_COEFF_READBACK_EN
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
`endif
    .o_sample_valid(o_sample_valid),
    .o_lp_a0(o_lp_a0), .o_lp_a1(o_lp_a1), .o_lp_a2(o_lp_a2), .o_lp_b1(o_lp_b1), .o_lp_b2(o_lp_b2),
    .o_hp_a0(o_hp_a0), .o_hp_a1(o_hp_a1), .o_hp_a2(o_hp_a2), .o_hp_b1(o_hp_b1), .o_hp_b2(o_hp_b2),
    .o_commit_pending(o_commit_pending), .o_commit_done(o_commit_done),
    .o_wr_reject(o_wr_reject), .o_coeff_valid(o_coeff_valid), .o_swap_count(o_swap_count)
  );

  // Clock and watchdog
  always #5 i_mck = ~i_mck;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]     exp_q[$];
  logic             rej_q[$];
  logic [NBITS-1:0] sh_m   [NC];
  logic [NBITS-1:0] act_m  [NC];
  logic [NBITS-1:0] zero_m [NC];
  logic [CNT_W-1:0] cnt_m;
  logic             prev_sv = 1'b0;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  function automatic logic [W-1:0] pack(input logic [NBITS-1:0] c [NC], input logic [CNT_W-1:0] cnt,
                                        input logic v, input logic p);
    return {c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], c[8], c[9], cnt, v, p};
  endfunction

  function automatic logic [W-1:0] actual();
    return {o_lp_a0, o_lp_a1, o_lp_a2, o_lp_b1, o_lp_b2, o_hp_a0, o_hp_a1, o_hp_a2, o_hp_b1, o_hp_b2,
            o_swap_count, o_coeff_valid, o_commit_pending};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge i_mck);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [NBITS-1:0] d, input bit accept);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    tick();
    i_wr_en = 1'b0;
    if (accept) sh_m[int'(a)] = d;
    else rej_q.push_back(1'b1);
  endtask

  task automatic push_swap();
    cnt_m = cnt_m + CNT_W'(1);
    exp_q.push_back(pack(sh_m, cnt_m, 1'b1, 1'b0));
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge i_mck);
      if (o_commit_done) begin
        lat = i;
        break;
      end
    end
    check("commit_done_seen", W'(lat > 0), W'(1));
  endtask

  task automatic do_commit(output int lat);
    push_swap();
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    wait_done(8, lat);
    act_m = sh_m;
    tick();
  endtask

  // Monitor / scoreboard
  always @(negedge i_mck) begin
    if (!i_rstn) begin
      prev_sv = 1'b0;
    end else begin
      check("sample_valid_delay", W'(o_sample_valid), W'(prev_sv));
      prev_sv = i_sample_valid;
      if (o_commit_done) begin
        if (exp_q.size() == 0) check("unexpected_done", W'(o_commit_done), W'(0));
        else check("swap_set", actual(), exp_q.pop_front());
      end
      if (o_wr_reject) begin
        if (rej_q.size() == 0) check("unexpected_reject", W'(o_wr_reject), W'(0));
        else check("reject_pulse", W'(o_wr_reject), W'(rej_q.pop_front()));
      end
    end
  end

  initial begin
    int lat;
    i_rstn = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_commit = 1'b0;
    i_sample_valid = 1'b0; i_busy_l = 1'b0; i_busy_r = 1'b0;
`ifdef XOVER_COEFF_READBACK_EN
    i_rd_addr = '0;
`endif
    cnt_m = '0;
    for (int i = 0; i < NC; i++) begin
      sh_m[i] = '0; act_m[i] = '0; zero_m[i] = '0;
    end
    repeat (3) @(posedge i_mck);
    #1 i_rstn = 1'b1;

    // Reset state and sample-valid re-timing
    @(negedge i_mck);
    check("reset_state", actual(), pack(zero_m, '0, 1'b0, 1'b0));
    check("reset_pulses", W'({o_commit_done, o_wr_reject, o_sample_valid}), W'(0));
    repeat (9) tick();
    i_sample_valid = 1'b1;
    @(negedge i_mck);
    check("sv_same_cycle", W'(o_sample_valid), W'(0));
    tick();
    i_sample_valid = 1'b0;
    @(negedge i_mck);
    check("sv_next_cycle", W'(o_sample_valid), W'(1));
    tick();
    @(negedge i_mck);
    check("sv_after_pulse", W'(o_sample_valid), W'(0));
    tick();

    // First commit on an idle datapath: swap two cycles after commit
    wr(4'd0, 32'h0040_0000, 1'b1);
    wr(4'd9, 32'hFF80_0000, 1'b1);
    push_swap();
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    @(negedge i_mck);
    check("pending_cycle1", W'({o_commit_pending, o_commit_done, o_coeff_valid}), W'(3'b100));
    tick();
    @(negedge i_mck);
    check("swap_cycle2", W'({o_commit_pending, o_commit_done, o_coeff_valid}), W'(3'b011));
    act_m = sh_m;
    check("first_swap_values", actual(), pack(act_m, 8'd1, 1'b1, 1'b0));
    tick();

    // Commit just after a sample while both engines are busy; pending write and commit ignored
    wr(4'd2, 32'h0011_2233, 1'b1);
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    push_swap();
    i_commit = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      i_busy_l  = (k < 29);
      i_busy_r  = 1'b1;
      i_wr_en   = (k == 5);
      i_wr_addr = 4'd1;
      i_wr_data = 32'hDEAD_BEEF;
      i_commit  = (k == 8);
      if (k == 5) rej_q.push_back(1'b1);
      @(negedge i_mck);
      check("hold_during_busy", actual(), pack(act_m, cnt_m - CNT_W'(1), 1'b1, 1'b1));
      check("no_swap_while_busy", W'(o_commit_done), W'(0));
      tick();
    end
    i_busy_l = 1'b0; i_busy_r = 1'b0; i_wr_en = 1'b0; i_commit = 1'b0;
    wait_done(8, lat);
    check("swap_after_busy_latency", W'(lat), W'(2));
    act_m = sh_m;
    tick();

    // Out-of-range write, then write and commit in the same cycle
    wr(4'd12, 32'h5555_AAAA, 1'b0);
    i_wr_en = 1'b1; i_wr_addr = 4'd3; i_wr_data = 32'h1234_5678; i_commit = 1'b1;
    sh_m[3] = 32'h1234_5678;
    push_swap();
    tick();
    i_wr_en = 1'b0; i_commit = 1'b0;
    wait_done(8, lat);
    check("same_cycle_latency", W'(lat), W'(2));
    check("lp_b1_after_swap", W'(o_lp_b1), W'(32'h1234_5678));
    act_m = sh_m;
    tick();

`ifdef XOVER_COEFF_READBACK_EN
    wr(4'd5, 32'h0AAA_5555, 1'b1);
    i_rd_addr = 4'd5;
    tick();
    @(negedge i_mck);
    check("readback_addr5", W'(o_rd_data), W'(32'h0AAA_5555));
    tick();
    i_rd_addr = 4'd12;
    tick();
    @(negedge i_mck);
    check("readback_addr12", W'(o_rd_data), W'(0));
    tick();
    i_rd_addr = 4'd3;
    tick();
    @(negedge i_mck);
    check("readback_addr3", W'(o_rd_data), W'(32'h1234_5678));
    tick();
`endif

    tick();
    check("swaps_drained", W'(exp_q.size()), W'(0));
    check("rejects_drained", W'(rej_q.size()), W'(0));

    // Reset asserted while a commit is pending
    i_busy_l = 1'b1;
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    @(negedge i_mck);
    check("pending_before_reset", W'(o_commit_pending), W'(1));
    #2 i_rstn = 1'b0;
    #1 check("reset_mid_pending", actual(), pack(zero_m, '0, 1'b0, 1'b0));
    sh_m = zero_m; act_m = zero_m; cnt_m = '0;
    @(posedge i_mck);
    #1 i_rstn = 1'b1;
    i_busy_l = 1'b0;
    repeat (4) tick();
    @(negedge i_mck);
    check("no_stale_swap", W'({o_commit_pending, o_commit_done}), W'(0));
    tick();

    // 256 commits from a cleared bank: the first proves the shadow was cleared, count wraps to 0
    for (int n = 0; n < 256; n++) do_commit(lat);
    @(negedge i_mck);
    check("swap_count_wrap", W'(o_swap_count), W'(0));
    check("coeff_valid_after_wrap", W'(o_coeff_valid), W'(1));
    tick();
    check("final_swaps_drained", W'(exp_q.size()), W'(0));
    check("final_rejects_drained", W'(rej_q.size()), W'(0));

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xover_coeff_ctrl.md
Name: xover_coeff_ctrl

Overview:
- Coefficient configurator and sample gate for the stereo Linkwitz-Riley crossover; sits between the host register interface and the left and right crossover IIR engines.
- Host writes 10 biquad coefficients into a shadow bank, then issues a commit.
- The block copies shadow to active atomically, only in a window where neither engine is mid-computation, so both channels always use one coherent coefficient set per sample.
- Drives the engines' coefficient inputs and re-times the sample-valid strobe to them.

Parameters:
- NBITS, 32, coefficient width (matches c_IIR_NBITS); signed fixed point with NBITS-2 fractional bits.
- CNT_W, 8, width of the swap counter.

Ports:
- i_mck  in  1  master clock (256*fs).
- i_rstn  in  1  asynchronous active-low reset.
- i_wr_en  in  1  shadow write strobe.
- i_wr_addr  in  4  coefficient index. 0-4: lp_a0,a1,a2,b1,b2. 5-9: hp_a0,a1,a2,b1,b2.
- i_wr_data  in  NBITS  signed coefficient.
- i_commit  in  1  request shadow-to-active copy; single-cycle pulse.
- i_sample_valid  in  1  new L/R sample strobe from the I2S receiver.
- i_busy_l, i_busy_r  in  1 each  engine busy flags.
- o_sample_valid  out  1  registered copy of i_sample_valid to both engines.
- o_lp_a0..o_lp_b2, o_hp_a0..o_hp_b2  out  NBITS each  active coefficients (10 buses).
- o_commit_pending  out  1  commit accepted, swap not yet done.
- o_commit_done  out  1  one-cycle pulse in the swap cycle.
- o_wr_reject  out  1  one-cycle pulse when a write is dropped.
- o_coeff_valid  out  1  high after the first completed swap.
- o_swap_count  out  CNT_W  completed swaps, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release):
  - Shadow and active banks = 0.
  - All outputs = 0.
  - State = IDLE.
  - Engines produce silence until the first commit.
- o_sample_valid = i_sample_valid delayed by exactly 1 cycle; never suppressed or stretched.
- Shadow write, accepted in IDLE only when i_wr_en=1 and addr<=9: shadow[addr] <= i_wr_data on that edge.
  - addr 10-15: write dropped, o_wr_reject pulses the next cycle.
  - Any write in PENDING or SWAP: dropped, o_wr_reject pulses.
- Quiet condition Q = !i_sample_valid & !o_sample_valid & !v_d2 & !i_busy_l & !i_busy_r.
  - v_d2 = o_sample_valid delayed 1 more cycle; it covers the engines' busy-assert lag.
- FSM:
  - IDLE:
    - i_commit=1 -> PENDING; o_commit_pending=1 from the next cycle.
    - If i_wr_en and i_commit occur in the same cycle, the write lands first and is included in the commit.
  - PENDING: wait in this state while Q=0. Q=1 -> SWAP.
    - Further i_commit pulses are ignored (no queueing, no error).
  - SWAP (exactly 1 cycle):
    - active <= shadow, all 10 coefficients on one edge.
    - o_commit_done=1, o_coeff_valid<=1.
    - o_swap_count increments.
    - o_commit_pending<=0.
    - -> IDLE.
    - Swap in the same cycle as a new i_sample_valid is permitted. The engine registers the sample on that edge and reads coefficients from the next cycle on, so it uses the new set for the entire sample.
- Latency: commit to swap is 2 cycles minimum with an idle datapath. Worst case is about 32 cycles, covering one full 29-cycle engine pass plus guard.
- Coefficient outputs are register outputs with no combinational path from inputs and only change in SWAP.
- Reset mid-PENDING: commit lost, banks cleared, o_coeff_valid=0.

Optional Feature:
- Macro XOVER_COEFF_READBACK_EN.
  - Defined: adds input i_rd_addr (4 bits) and output o_rd_data (NBITS bits).
    - o_rd_data is registered 1-cycle readback of shadow[i_rd_addr].
    - Addr >9 reads 0.
    - Reads are allowed in every state and have no side effects.
  - Undefined: both ports are absent and no read mux is synthesised.

Test Plan:
- Reset then idle:
  - All coefficient outputs 0, o_coeff_valid=0, o_swap_count=0.
  - i_sample_valid pulse at cycle 10 -> o_sample_valid pulse at cycle 11.
- Write lp_a0=0x0040_0000 (addr 0) and hp_b2=0xFF80_0000 (addr 9), commit with busy low and no samples:
  - o_commit_done 2 cycles after commit.
  - o_lp_a0=0x0040_0000, o_hp_b2=0xFF80_0000, others 0, o_swap_count=1.
- Commit one cycle after i_sample_valid, with engines busy for 29 cycles from cycle+2:
  - Swap not before busy falls on both engines.
  - o_coeff_valid rises exactly in the swap cycle.
  - Active values are stable during busy.
- Write attempts:
  - Write addr 12 -> o_wr_reject pulse, shadow unchanged.
  - Write during PENDING -> o_wr_reject pulse, and the value is not in the swapped set.
- Same-cycle write addr 3 = 0x1234_5678 with i_commit in IDLE -> o_lp_b1=0x1234_5678 after swap.
- 256 commits -> o_swap_count wraps to 0.
- With XOVER_COEFF_READBACK_EN defined: read addr 5 after writing 0x0AAA_5555 -> o_rd_data=0x0AAA_5555 the next cycle.
- Reset asserted mid-PENDING -> pending cleared, banks 0.
